// File: rtl/chebyshev_sequencer_if.sv
// Stream handshake bundle for chebyshev_sequencer: sample input (s_*) and
// result output (m_*). The producer/consumer side uses master, the
// sequencer uses slave.
interface chebyshev_sequencer_if #(
  parameter int WL = 8
);
  logic                 s_valid;
  logic                 s_ready;
  logic signed [WL-1:0] s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic signed [WL-1:0] m_data;

  modport master (
    output s_valid,
    output s_data,
    output m_ready,
    input  s_ready,
    input  m_valid,
    input  m_data
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  m_ready,
    output s_ready,
    output m_valid,
    output m_data
  );
endinterface

// File: rtl/chebyshev_sequencer.sv
// Chebyshev coefficient sequencer: accepts one sample, presents it to an
// external datapath together with ORDER stored coefficients (one per cycle),
// waits PIPE_LAT cycles for the datapath, captures its result and holds it
// on the output handshake until consumed. No arithmetic happens here.
module chebyshev_sequencer #(
  parameter int WL       = 8,
  parameter int CL       = 8,
  parameter int ORDER    = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_addr,
  input  logic signed [CL-1:0] cfg_data,
  chebyshev_sequencer_if.slave stream,
  output logic signed [WL-1:0] dp_data_in,
  output logic signed [CL-1:0] dp_coeff_in,
  input  logic signed [WL-1:0] dp_data_out,
  output logic                 busy
);

  localparam int KW = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam int WW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(ORDER - 1);
  localparam logic [WW-1:0] W_LOAD = WW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t               state_q,       state_d;
  logic [KW-1:0]        k_q,           k_d;
  logic [WW-1:0]        wait_cnt_q,    wait_cnt_d;
  logic signed [WL-1:0] x_reg_q,       x_reg_d;
  logic signed [CL-1:0] coeff_q [ORDER];
  logic signed [CL-1:0] coeff_d [ORDER];
  logic                 m_valid_q,     m_valid_d;
  logic signed [WL-1:0] m_data_q,      m_data_d;
  logic                 s_ready_q,     s_ready_d;
  logic                 busy_q,        busy_d;
  logic signed [WL-1:0] dp_data_in_q,  dp_data_in_d;
  logic signed [CL-1:0] dp_coeff_in_q, dp_coeff_in_d;
  logic signed [CL-1:0] coeff_sel;

  // Next-state logic: FSM transitions, coefficient bank writes and the
  // registered-output values derived from the upcoming state.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    wait_cnt_d = wait_cnt_q;
    x_reg_d    = x_reg_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    coeff_sel  = '0;
    for (int i = 0; i < ORDER; i++) begin
      coeff_d[i] = coeff_q[i];
    end

    // Writes are honoured only while idle; out-of-range addresses match no
    // entry and therefore fall away. A write coinciding with a sample
    // acceptance lands before the first ISSUE cycle and is seen by it.
    if (cfg_we && (state_q == IDLE)) begin
      for (int i = 0; i < ORDER; i++) begin
        if (cfg_addr == 4'(i)) begin
          coeff_d[i] = cfg_data;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (stream.s_valid) begin
          x_reg_d = stream.s_data;
          k_d     = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (k_q == K_LAST) begin
          k_d        = '0;
          wait_cnt_d = W_LOAD;
          state_d    = DRAIN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DRAIN: begin
        if (wait_cnt_q == '0) begin
          m_data_d  = dp_data_out;
          m_valid_d = 1'b1;
          state_d   = HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q - WW'(1);
        end
      end
      HOLD: begin
        if (stream.m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    for (int i = 0; i < ORDER; i++) begin
      if (k_d == KW'(i)) begin
        coeff_sel = coeff_d[i];
      end
    end

    s_ready_d     = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    dp_data_in_d  = (state_d == ISSUE) ? x_reg_d : '0;
    dp_coeff_in_d = (state_d == ISSUE) ? coeff_sel : '0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= IDLE;
      k_q           <= '0;
      wait_cnt_q    <= '0;
      x_reg_q       <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      s_ready_q     <= 1'b1;
      busy_q        <= 1'b0;
      dp_data_in_q  <= '0;
      dp_coeff_in_q <= '0;
      for (int i = 0; i < ORDER; i++) begin
        coeff_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      wait_cnt_q    <= wait_cnt_d;
      x_reg_q       <= x_reg_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      s_ready_q     <= s_ready_d;
      busy_q        <= busy_d;
      dp_data_in_q  <= dp_data_in_d;
      dp_coeff_in_q <= dp_coeff_in_d;
      for (int i = 0; i < ORDER; i++) begin
        coeff_q[i] <= coeff_d[i];
      end
    end
  end

  assign stream.s_ready = s_ready_q;
  assign stream.m_valid = m_valid_q;
  assign stream.m_data  = m_data_q;
  assign dp_data_in     = dp_data_in_q;
  assign dp_coeff_in    = dp_coeff_in_q;
  assign busy           = busy_q;

endmodule

// File: doc/chebyshev_sequencer.md
CHEBYSHEV_SEQUENCER -- requirements
Module: chebyshev_sequencer

Interface
REQ-001 The block SHALL have parameter WL, default 8, meaning the data word length.
REQ-002 The block SHALL have parameter CL, default 8, meaning the coefficient word length.
REQ-003 The block SHALL have parameter ORDER, default 4, range 1..16, meaning the number of coefficients issued per sample.
REQ-004 The block SHALL have parameter PIPE_LAT, default 2, range >=1, meaning the datapath latency in cycles.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all logic acts on its rising edge.
REQ-006 The block SHALL have port resetn, input, 1 bit: synchronous active-low reset.
REQ-007 The block SHALL have port cfg_we, input, 1 bit: coefficient write enable.
REQ-008 The block SHALL have port cfg_addr, input, 4 bits: coefficient index.
REQ-009 The block SHALL have port cfg_data, input, CL bits signed: coefficient value.
REQ-010 The block SHALL have ports s_valid (input, 1), s_ready (output, 1) and s_data (input, WL signed): the sample input handshake.
REQ-011 The block SHALL have ports m_valid (output, 1), m_ready (input, 1) and m_data (output, WL signed): the result output handshake.
REQ-012 The block SHALL have port dp_data_in, output, WL bits signed: drives the datapath data input.
REQ-013 The block SHALL have port dp_coeff_in, output, CL bits signed: drives the datapath coefficient input.
REQ-014 The block SHALL have port dp_data_out, input, WL bits signed: the datapath result.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, DRAIN and HOLD; there SHALL be no other reachable state.
REQ-017 In IDLE: s_ready=1; s_valid&&s_ready latches s_data into x_reg, clears k=0 and moves to ISSUE.
REQ-018 In ISSUE: dp_data_in=x_reg, dp_coeff_in=coeff[k]; k increments each cycle; the ISSUE cycle with k==ORDER-1 moves to DRAIN, loading wait_cnt=PIPE_LAT-1. ISSUE SHALL last exactly ORDER cycles.
REQ-019 In DRAIN: wait_cnt decrements each cycle; the cycle with wait_cnt==0 captures dp_data_out into m_data, sets m_valid=1 and moves to HOLD. DRAIN SHALL last exactly PIPE_LAT cycles.
REQ-020 In HOLD: m_valid=1 and m_data SHALL remain stable until m_ready=1; the cycle with m_ready=1 clears m_valid and moves to IDLE.
REQ-021 Latency: with acceptance at edge t0, m_valid SHALL rise after edge t0+ORDER+PIPE_LAT.
REQ-022 s_ready SHALL be 0 in ISSUE, DRAIN and HOLD, so a new sample is accepted only from the cycle after the HOLD exit (no overlap).
REQ-023 Outside ISSUE, dp_data_in and dp_coeff_in SHALL be 0.
REQ-024 Coefficient bank: ORDER x CL registers; cfg_we=1 in IDLE with cfg_addr<ORDER writes cfg_data at the next edge.
REQ-025 A cfg_we asserted in a non-IDLE state, or with cfg_addr>=ORDER, SHALL be ignored with no state change.
REQ-026 cfg_we and an s_valid acceptance in the same IDLE cycle SHALL both take effect; the written coefficient is used by that sample.
REQ-027 No arithmetic is performed by this block; all values pass through with full width and no truncation.

Reset
REQ-028 resetn=0 at a rising edge SHALL force: state=IDLE, k=0, wait_cnt=0, x_reg=0, all coefficients=0, m_valid=0, m_data=0, dp_data_in=0, dp_coeff_in=0, busy=0.
REQ-029 Reset asserted mid-operation (any state) SHALL abort the sample with no m_valid pulse; s_ready=1 SHALL apply on the first cycle after resetn returns to 1.

Verification
REQ-030 Load: write coefficients 15,1,0,3 to addresses 0..3 (ORDER=4, PIPE_LAT=2), then send s_data=43 -> dp_data_in=43 for 4 consecutive cycles with dp_coeff_in=15,1,0,3; m_valid rises 6 edges after acceptance.
REQ-031 Capture: the bench drives dp_data_out=0x5A on the final DRAIN cycle -> m_data=0x5A.
REQ-032 Backpressure: hold m_ready=0 for 5 cycles in HOLD -> m_valid=1, m_data unchanged, s_ready=0, busy=1 throughout; m_ready=1 -> IDLE on the next edge.
REQ-033 Guarded config: write addr 0 <- 7 while busy, and write addr 7 <- 9 in IDLE -> coeff[0] remains 15 and the next sample issues 15,1,0,3.
REQ-034 Reset in ISSUE at k=2 -> next cycle: IDLE, all outputs 0, no m_valid; a following sample issues coefficients 0,0,0,0.
REQ-035 Simultaneous events: cfg_we (addr 0 <- 2) together with an s_valid acceptance -> first issued dp_coeff_in=2.
